// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - hazard_state_t : sequencing FSM states
//   - FWD_*          : operand forwarding-mux select codes
//   - COND_BA/BN     : Bicc condition codes that never read icc
//   - reg_match()    : register compare that never matches r0
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LD_STALL = 2'b01,
        CC_STALL = 2'b10,
        ANNUL    = 2'b11
    } hazard_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_EX  = 2'b11;

    localparam logic [3:0] COND_BA = 4'b1000;
    localparam logic [3:0] COND_BN = 4'b0000;

    // r0 is hardwired to zero, so it is never a producer or a consumer.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/operand_forward_select.sv
// Forwarding-mux select for one ID operand.
// Ports:
//   src, use_src        : register field of the operand and its use bit
//   id_live             : instruction in ID is valid and not in reset
//   ex_rd/ex_rf_en/ex_load, mem_rd/mem_rf_en, wb_rd/wb_rf_en : producers
//   sel                 : 00 reg file, 01 WB, 10 MEM, 11 EX (ALU)
module operand_forward_select
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic       id_live,
    input  logic [4:0] ex_rd,
    input  logic       ex_rf_en,
    input  logic       ex_load,
    input  logic [4:0] mem_rd,
    input  logic       mem_rf_en,
    input  logic [4:0] wb_rd,
    input  logic       wb_rf_en,
    output logic [1:0] sel
);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        sel = FWD_RF;
        if (use_src && id_live) begin
            // A load's data is not ready in EX; that case is a stall, not a forward.
            if (ex_rf_en && !ex_load && reg_match(src, ex_rd))
                sel = FWD_EX;
            else if (mem_rf_en && reg_match(src, mem_rd))
                sel = FWD_MEM;
            else if (wb_rf_en && reg_match(src, wb_rd))
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequencing controller for the five-stage SPARC pipeline.
// Watches ID/EX/MEM/WB register and icc usage and drives:
//   forwardMX1/2/3          : operand mux selects for rs1, rs2, rd (store data)
//   LE_PC, LE_IF_ID         : PC/nPC and IF/ID load enables (low = stall)
//   bubble_ID_EX            : force ID/EX control to NOP at next edge
//   annul_IF_ID             : clear IF/ID at next edge (annulled delay slot)
//   ID_valid                : instruction in ID is live
//   stall_cnt, annul_cnt    : saturating debug event counters
// clk pipeline clock, clr asynchronous active-high reset.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             ID_use_rd,
    input  logic             ID_branch,
    input  logic [3:0]       ID_cond,
    input  logic             ID_annul,
    input  logic             branch_taken,
    input  logic [4:0]       EX_RD,
    input  logic [4:0]       MEM_RD,
    input  logic [4:0]       WB_RD,
    input  logic             EX_rf_en,
    input  logic             MEM_rf_en,
    input  logic             WB_rf_en,
    input  logic             EX_load,
    input  logic             EX_cc_en,
    output logic [1:0]       forwardMX1,
    output logic [1:0]       forwardMX2,
    output logic [1:0]       forwardMX3,
    output logic             LE_PC,
    output logic             LE_IF_ID,
    output logic             bubble_ID_EX,
    output logic             annul_IF_ID,
    output logic             ID_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] annul_cnt
);

    hazard_state_t state;
    hazard_state_t next_state;

    logic id_live;
    logic ld_hazard;
    logic cc_hazard;
    logic annul_hit;
    logic stall;

    // While the annulled slot sits in ID it must not cause any hazard,
    // forward or annul. Decisions are also gated while clr is held so every
    // output shows its reset value immediately, even with hazard inputs present.
    assign ID_valid = (state != ANNUL);
    assign id_live  = ID_valid && !clr;

    assign ld_hazard = id_live && EX_load && EX_rf_en &&
                       ((ID_use_rs1 && reg_match(ID_rs1, EX_RD)) ||
                        (ID_use_rs2 && reg_match(ID_rs2, EX_RD)) ||
                        (ID_use_rd  && reg_match(ID_rd,  EX_RD)));

    // BA and BN ignore icc, so an icc writer in EX does not delay them.
    assign cc_hazard = id_live && ID_branch && EX_cc_en &&
                       (ID_cond != COND_BA) && (ID_cond != COND_BN);

    assign stall = ld_hazard || cc_hazard;

    // A stalled branch makes no annul decision until it is released.
    // BA,a annuls its slot even though it is taken.
    assign annul_hit = id_live && ID_branch && ID_annul && !stall &&
                       (!branch_taken || (ID_cond == COND_BA));

    always_comb begin
        next_state = RUN;
        if (ld_hazard)
            next_state = LD_STALL;
        else if (cc_hazard)
            next_state = CC_STALL;
        else if (annul_hit)
            next_state = ANNUL;
    end

    assign LE_PC        = !stall;
    assign LE_IF_ID     = !stall;
    // The annulled slot is turned into a NOP on its way into EX.
    assign bubble_ID_EX = stall || (state == ANNUL);
    assign annul_IF_ID  = annul_hit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= RUN;
            stall_cnt <= '0;
            annul_cnt <= '0;
        end else begin
            state <= next_state;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (annul_hit && (annul_cnt != '1))
                annul_cnt <= annul_cnt + 1'b1;
        end
    end

    operand_forward_select u_fwd_rs1 (
        .src      (ID_rs1),
        .use_src  (ID_use_rs1),
        .id_live  (id_live),
        .ex_rd    (EX_RD),
        .ex_rf_en (EX_rf_en),
        .ex_load  (EX_load),
        .mem_rd   (MEM_RD),
        .mem_rf_en(MEM_rf_en),
        .wb_rd    (WB_RD),
        .wb_rf_en (WB_rf_en),
        .sel      (forwardMX1)
    );

    operand_forward_select u_fwd_rs2 (
        .src      (ID_rs2),
        .use_src  (ID_use_rs2),
        .id_live  (id_live),
        .ex_rd    (EX_RD),
        .ex_rf_en (EX_rf_en),
        .ex_load  (EX_load),
        .mem_rd   (MEM_RD),
        .mem_rf_en(MEM_rf_en),
        .wb_rd    (WB_RD),
        .wb_rf_en (WB_rf_en),
        .sel      (forwardMX2)
    );

    operand_forward_select u_fwd_rd (
        .src      (ID_rd),
        .use_src  (ID_use_rd),
        .id_live  (id_live),
        .ex_rd    (EX_RD),
        .ex_rf_en (EX_rf_en),
        .ex_load  (EX_load),
        .mem_rd   (MEM_RD),
        .mem_rf_en(MEM_rf_en),
        .wb_rd    (WB_RD),
        .wb_rf_en (WB_rf_en),
        .sel      (forwardMX3)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. Counters are built 4 bits
// wide so saturation is reachable in a few cycles.
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic [4:0]       ID_rs1, ID_rs2, ID_rd;
    logic             ID_use_rs1, ID_use_rs2, ID_use_rd;
    logic             ID_branch;
    logic [3:0]       ID_cond;
    logic             ID_annul;
    logic             branch_taken;
    logic [4:0]       EX_RD, MEM_RD, WB_RD;
    logic             EX_rf_en, MEM_rf_en, WB_rf_en;
    logic             EX_load, EX_cc_en;
    logic [1:0]       forwardMX1, forwardMX2, forwardMX3;
    logic             LE_PC, LE_IF_ID, bubble_ID_EX, annul_IF_ID, ID_valid;
    logic [CNT_W-1:0] stall_cnt, annul_cnt;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clr         (clr),
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .ID_rd       (ID_rd),
        .ID_use_rs1  (ID_use_rs1),
        .ID_use_rs2  (ID_use_rs2),
        .ID_use_rd   (ID_use_rd),
        .ID_branch   (ID_branch),
        .ID_cond     (ID_cond),
        .ID_annul    (ID_annul),
        .branch_taken(branch_taken),
        .EX_RD       (EX_RD),
        .MEM_RD      (MEM_RD),
        .WB_RD       (WB_RD),
        .EX_rf_en    (EX_rf_en),
        .MEM_rf_en   (MEM_rf_en),
        .WB_rf_en    (WB_rf_en),
        .EX_load     (EX_load),
        .EX_cc_en    (EX_cc_en),
        .forwardMX1  (forwardMX1),
        .forwardMX2  (forwardMX2),
        .forwardMX3  (forwardMX3),
        .LE_PC       (LE_PC),
        .LE_IF_ID    (LE_IF_ID),
        .bubble_ID_EX(bubble_ID_EX),
        .annul_IF_ID (annul_IF_ID),
        .ID_valid    (ID_valid),
        .stall_cnt   (stall_cnt),
        .annul_cnt   (annul_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic idle();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_rd = 5'd0;
        ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0; ID_use_rd = 1'b0;
        ID_branch = 1'b0; ID_cond = 4'b0000; ID_annul = 1'b0; branch_taken = 1'b0;
        EX_RD = 5'd0; MEM_RD = 5'd0; WB_RD = 5'd0;
        EX_rf_en = 1'b0; MEM_rf_en = 1'b0; WB_rf_en = 1'b0;
        EX_load = 1'b0; EX_cc_en = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flow(input string tag, input logic le, input logic bub, input logic ann);
        check({tag, "_le_pc"},  {31'd0, LE_PC},        {31'd0, le});
        check({tag, "_le_ifid"}, {31'd0, LE_IF_ID},    {31'd0, le});
        check({tag, "_bubble"}, {31'd0, bubble_ID_EX}, {31'd0, bub});
        check({tag, "_annul"},  {31'd0, annul_IF_ID},  {31'd0, ann});
    endtask

    initial begin
        idle();
        clr = 1'b1;
        #2;
        // Reset state
        check("rst_mx1", {30'd0, forwardMX1}, 32'd0);
        check("rst_mx2", {30'd0, forwardMX2}, 32'd0);
        check("rst_mx3", {30'd0, forwardMX3}, 32'd0);
        check_flow("rst", 1'b1, 1'b0, 1'b0);
        check("rst_valid", {31'd0, ID_valid}, 32'd1);
        check("rst_scnt", {28'd0, stall_cnt}, 32'd0);
        check("rst_acnt", {28'd0, annul_cnt}, 32'd0);
        step();
        clr = 1'b0;
        step();

        // Forwarding priority for rs1 = r5
        ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
        EX_RD = 5'd5; EX_rf_en = 1'b1; MEM_RD = 5'd5; MEM_rf_en = 1'b1; WB_RD = 5'd5; WB_rf_en = 1'b1;
        #1 check("fwd_ex", {30'd0, forwardMX1}, 32'd3);
        EX_rf_en = 1'b0;
        #1 check("fwd_mem", {30'd0, forwardMX1}, 32'd2);
        MEM_rf_en = 1'b0;
        #1 check("fwd_wb", {30'd0, forwardMX1}, 32'd1);
        ID_rs1 = 5'd0; EX_RD = 5'd0; MEM_RD = 5'd0; WB_RD = 5'd0; EX_rf_en = 1'b1; MEM_rf_en = 1'b1;
        #1 check("fwd_r0", {30'd0, forwardMX1}, 32'd0);
        // Use bit gates rs2; rd forwards from MEM
        idle();
        ID_rs2 = 5'd6; ID_use_rs2 = 1'b0; ID_rd = 5'd7; ID_use_rd = 1'b1;
        EX_RD = 5'd6; EX_rf_en = 1'b1; MEM_RD = 5'd7; MEM_rf_en = 1'b1;
        #1 check("fwd_nouse", {30'd0, forwardMX2}, 32'd0);
        check("fwd_rd_mem", {30'd0, forwardMX3}, 32'd2);
        check_flow("fwd_noload", 1'b1, 1'b0, 1'b0);
        step();

        // Load-use: EX load r3, ID reads rs2 = r3
        idle();
        EX_load = 1'b1; EX_rf_en = 1'b1; EX_RD = 5'd3; ID_rs2 = 5'd3; ID_use_rs2 = 1'b1;
        #1 check_flow("ld", 1'b0, 1'b1, 1'b0);
        check("ld_mx2", {30'd0, forwardMX2}, 32'd0);
        step();
        check("ld_scnt", {28'd0, stall_cnt}, 32'd1);
        EX_load = 1'b0; EX_rf_en = 1'b0; EX_RD = 5'd0; MEM_RD = 5'd3; MEM_rf_en = 1'b1;
        #1 check("ld_after_mx2", {30'd0, forwardMX2}, 32'd2);
        check_flow("ld_after", 1'b1, 1'b0, 1'b0);
        step();
        check("ld_scnt_hold", {28'd0, stall_cnt}, 32'd1);

        // CC hazard: ADDcc in EX, BNE in ID
        idle();
        EX_cc_en = 1'b1; ID_branch = 1'b1; ID_cond = 4'b1001;
        #1 check_flow("cc", 1'b0, 1'b1, 1'b0);
        step();
        check("cc_scnt", {28'd0, stall_cnt}, 32'd2);
        EX_cc_en = 1'b0;
        #1 check_flow("cc_after", 1'b1, 1'b0, 1'b0);
        ID_cond = 4'b1000; EX_cc_en = 1'b1;
        #1 check_flow("cc_ba", 1'b1, 1'b0, 1'b0);
        step();
        check("cc_ba_scnt", {28'd0, stall_cnt}, 32'd2);

        // BNE,a not taken -> annul, slot invalid next cycle
        idle();
        ID_branch = 1'b1; ID_cond = 4'b1001; ID_annul = 1'b1; branch_taken = 1'b0;
        #1 check_flow("an", 1'b1, 1'b0, 1'b1);
        step();
        check("an_acnt", {28'd0, annul_cnt}, 32'd1);
        idle();
        ID_rs1 = 5'd4; ID_use_rs1 = 1'b1; EX_RD = 5'd4; EX_rf_en = 1'b1;
        #1 check("an_valid", {31'd0, ID_valid}, 32'd0);
        check("an_mx1", {30'd0, forwardMX1}, 32'd0);
        check_flow("an_slot", 1'b1, 1'b1, 1'b0);
        step();
        check("an_acnt_hold", {28'd0, annul_cnt}, 32'd1);
        check("an_valid_back", {31'd0, ID_valid}, 32'd1);
        check("an_mx1_back", {30'd0, forwardMX1}, 32'd3);

        // BA,a taken annuls; BNE,a taken does not
        idle();
        ID_branch = 1'b1; ID_cond = 4'b1000; ID_annul = 1'b1; branch_taken = 1'b1;
        #1 check("ba_a_annul", {31'd0, annul_IF_ID}, 32'd1);
        step();
        check("ba_a_acnt", {28'd0, annul_cnt}, 32'd2);
        idle();
        step();
        ID_branch = 1'b1; ID_cond = 4'b1001; ID_annul = 1'b1; branch_taken = 1'b1;
        #1 check_flow("bne_a_taken", 1'b1, 1'b0, 1'b0);

        // Stalled BNE,a: no annul until the CC stall releases
        branch_taken = 1'b0; EX_cc_en = 1'b1;
        #1 check_flow("stl_br", 1'b0, 1'b1, 1'b0);
        step();
        check("stl_br_acnt", {28'd0, annul_cnt}, 32'd2);
        EX_cc_en = 1'b0;
        #1 check_flow("stl_br_rel", 1'b1, 1'b0, 1'b1);
        step();
        check("stl_br_cnts", {24'd0, stall_cnt, annul_cnt}, {24'd0, 4'd3, 4'd3});
        idle();
        step();

        // Simultaneous load-use and CC hazard, then saturate stall_cnt
        EX_load = 1'b1; EX_rf_en = 1'b1; EX_RD = 5'd3; ID_rs1 = 5'd3; ID_use_rs1 = 1'b1;
        ID_branch = 1'b1; ID_cond = 4'b1001; EX_cc_en = 1'b1;
        #1 check_flow("both", 1'b0, 1'b1, 1'b0);
        step();
        check("both_scnt", {28'd0, stall_cnt}, 32'd4);
        ID_branch = 1'b0; EX_cc_en = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check("sat_full", {28'd0, stall_cnt}, 32'd15);
        step();
        check("sat_hold", {28'd0, stall_cnt}, 32'd15);

        // clr during LD_STALL with the hazard still applied
        clr = 1'b1;
        #1;
        check_flow("clr_mid", 1'b1, 1'b0, 1'b0);
        check("clr_mid_valid", {31'd0, ID_valid}, 32'd1);
        check("clr_mid_cnts", {24'd0, stall_cnt, annul_cnt}, 32'd0);
        check("clr_mid_mx1", {30'd0, forwardMX1}, 32'd0);
        clr = 1'b0;
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the five-stage SPARC pipeline. It sits beside the ID stage and watches register and condition-code usage across ID/EX/MEM/WB. It drives the three ID operand forwarding-mux selects and the PC/nPC and IF/ID load enables, inserts bubbles into ID/EX, and squashes annulled branch delay slots. It also keeps saturating stall/annul event counters for debug.

## Interface
Parameters:
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  pipeline clock
- clr  in  1  asynchronous, active-high reset
- ID_rs1, ID_rs2, ID_rd  in  5 each  source/store-data register fields of the instruction in ID
- ID_use_rs1, ID_use_rs2, ID_use_rd  in  1 each  the instruction in ID actually reads that field
- ID_branch  in  1  Bicc in ID
- ID_cond  in  4  branch condition field
- ID_annul  in  1  branch 'a' bit
- branch_taken  in  1  condition-handler result for the branch in ID
- EX_RD, MEM_RD, WB_RD  in  5 each  destination register per stage
- EX_rf_en, MEM_rf_en, WB_rf_en  in  1 each  register-file write enable per stage
- EX_load  in  1  load in EX
- EX_cc_en  in  1  instruction in EX writes icc
- forwardMX1, forwardMX2, forwardMX3  out  2 each  select 00 = reg file, 01 = WB_OUT, 10 = MEM_OUT, 11 = ALU_OUT
- LE_PC  out  1  PC/nPC register load enable
- LE_IF_ID  out  1  IF/ID load enable
- bubble_ID_EX  out  1  forces ID/EX control field to NOP at next edge
- annul_IF_ID  out  1  synchronous reset of IF/ID at next edge
- ID_valid  out  1  instruction in ID is live (not an annulled slot)
- stall_cnt, annul_cnt  out  CNT_W each  event counters

## Operation
- Register 0 never matches; no forward, no stall on r0.
- Forwarding per operand (MX1 ← rs1, MX2 ← rs2, MX3 ← rd), only if the matching use bit is set and ID_valid is 1.
  - Priority: EX (11) if EX_rf_en and !EX_load and EX_RD match.
  - Else MEM (10) if MEM_rf_en and match.
  - Else WB (01) if WB_rf_en and match.
  - Else 00.
- Load-use hazard: EX_load, EX_rf_en, EX_RD≠0 and matching any used ID source while ID_valid.
- CC hazard: ID_branch, ID_cond ∉ {1000, 0000}, EX_cc_en, ID_valid.
- Annul condition: ID_branch, ID_annul, ID_valid, no hazard, and (!branch_taken or ID_cond = 1000).
- FSM, state register, next state chosen each cycle:
  - RUN: normal flow.
  - LD_STALL: entered on load-use hazard.
  - CC_STALL: entered on CC hazard.
  - ANNUL: entered on annul condition.
  - Next state is computed every cycle from current inputs with priority LD_STALL > CC_STALL > ANNUL > RUN.
  - A hazard still present in a stall state keeps that state.
- Outputs driven combinationally from the current-cycle decision:
  - Stall: LE_PC=0, LE_IF_ID=0, bubble_ID_EX=1, annul_IF_ID=0.
  - Annul: LE_PC=1, LE_IF_ID=1, annul_IF_ID=1.
  - Otherwise: LE_PC=1, LE_IF_ID=1, bubble_ID_EX=0, annul_IF_ID=0.
- ID_valid = 0 while state = ANNUL (the annulled slot now sits in ID), else 1.
  - An invalid ID generates no hazard, no forward and no annul.
  - bubble_ID_EX=1 in ANNUL, so the slot never reaches EX.
- Counters increment by 1 on each edge whose decision was a stall (stall_cnt) or an annul (annul_cnt).
  - They saturate at all-ones; no wrap.

## Timing
- Reset (clr=1, async): state=RUN, stall_cnt=annul_cnt=0. Outputs are then forward*=00, LE_PC=1, LE_IF_ID=1, bubble_ID_EX=0, annul_IF_ID=0, ID_valid=1.
- Forward selects and stall outputs have zero-cycle latency, combinational from inputs and state.
- Load-use costs exactly one stall cycle. Next cycle the load is in MEM and the consumer forwards 10.
- CC stall costs one cycle; the branch re-evaluates with updated icc.
- Annul costs one dead cycle; the delay slot becomes a NOP.
- Simultaneous load-use and CC hazard → LD_STALL. The CC hazard is re-checked next cycle; EX then holds a bubble, so it is clear.
- Branch stalled in ID: no annul decision until the stall releases.
- clr mid-stall: immediate return to RUN, counters cleared, LE outputs high.

## Structure
- Shared package: FSM state encoding (RUN, LD_STALL, CC_STALL, ANNUL), forwarding select constants (FWD_RF/WB/MEM/EX), COND_BA=1000, COND_BN=0000.
- One sub-module, operand_forward_select: one instance per operand. Maps (reg, use, valid, stage RD/enables) to a 2-bit select.

## Test plan
- r5 written by ADD in EX, read as rs1 in ID → forwardMX1=11. With the writer in MEM → 10; in WB → 01. With reg = r0 → 00.
- EX load r3, ID reads rs2=r3 → one cycle LE_PC=0, LE_IF_ID=0, bubble_ID_EX=1, stall_cnt=1. Next cycle forwardMX2=10 and LE high.
- ADDcc in EX, BNE in ID → one CC_STALL cycle. BA in ID with ADDcc in EX → no stall.
- BNE,a with branch_taken=0 → annul_IF_ID=1 for one cycle, then ID_valid=0. Its rs1 matching EX_RD yields forwardMX1=00. annul_cnt=1.
- BA,a taken → annul. BNE,a taken → no annul.
- Force stall_cnt to all-ones, then stall → stays all-ones. Pulse clr during LD_STALL → outputs at reset values before the next clk edge.
